// File: rtl/ds1302_control_module_if.sv
// Bus between the DS1302 controller and the serial shift stage.
interface ds1302_control_module_if;
    // Handshake: the master raises Start_Sig (2'b10 write, 2'b01 read) together
    // with Words_Addr/Write_Data and holds all three unchanged until it samples
    // Done_Sig=1. The slave pulses Done_Sig for one cycle with Read_Data valid in
    // that same cycle. Start_Sig=2'b00 means no request is outstanding.
    logic [1:0] Start_Sig;
    logic [7:0] Words_Addr;
    logic [7:0] Write_Data;
    logic [7:0] Read_Data;
    logic       Done_Sig;

    modport master (
        output Start_Sig, Words_Addr, Write_Data,
        input  Read_Data, Done_Sig
    );

    modport slave (
        input  Start_Sig, Words_Addr, Write_Data,
        output Read_Data, Done_Sig
    );
endinterface

// File: rtl/ds1302_control_module.sv
// DS1302 sequencer: clears write-protect after reset, polls sec/min/hour at a
// fixed period, and writes a new time when requested. Every transaction runs
// ISSUE -> WAIT -> GAP; a timeout abandons the rest of the sequence.
module ds1302_control_module #(
    parameter logic [23:0] POLL_CYCLES    = 24'd5_000_000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       Set_Sig,
    input  logic [7:0] Set_Sec,
    input  logic [7:0] Set_Min,
    input  logic [7:0] Set_Hour,
    ds1302_control_module_if.master bus,
    output logic [7:0] Sec_Data,
    output logic [7:0] Min_Data,
    output logic [7:0] Hour_Data,
    output logic       Update_Sig,
    output logic       Busy,
    output logic       Err_Sig,
    output logic [3:0] o_dbg_state,
    output logic [1:0] o_dbg_phase
);
    typedef enum logic [3:0] {
        ST_INIT_WP, ST_IDLE, ST_SET_HR, ST_SET_MIN, ST_SET_SEC,
        ST_RD_SEC, ST_RD_MIN, ST_RD_HR, ST_REPORT
    } state_t;
    typedef enum logic [1:0] {PH_ISSUE, PH_WAIT, PH_GAP} phase_t;

    state_t r_state, w_state_n, w_seq;
    phase_t r_phase, w_phase_n;
    logic [1:0]  r_start, w_start_n;
    logic [7:0]  r_addr, w_addr_n, r_wdata, w_wdata_n;
    logic [7:0]  r_sec, w_sec_n, r_min, w_min_n, r_hour, w_hour_n;
    logic [23:0] r_poll, w_poll_n;
    logic [15:0] r_to, w_to_n;
    logic        r_gap, w_gap_n, r_abort, w_abort_n, r_err, w_err_n;
    logic        r_update, r_busy, w_set_start;
    logic        r_pend, w_pend_n;
    logic [7:0]  r_pb_sec, r_pb_min, r_pb_hour, w_pb_sec_n, w_pb_min_n, w_pb_hour_n;
    logic [7:0]  r_act_sec, r_act_min, r_act_hour, w_act_sec_n, w_act_min_n, w_act_hour_n;
    logic [17:0] w_cmd, w_cmd_nxt;

    // Command {Start_Sig, Words_Addr, Write_Data} for a transaction state.
    function automatic logic [17:0] cmd_of(input state_t s, input logic [7:0] hr,
                                           input logic [7:0] mn, input logic [7:0] sc);
        case (s)
            ST_INIT_WP: cmd_of = {2'b10, 8'h8E, 8'h00};
            ST_SET_HR:  cmd_of = {2'b10, 8'h84, hr};
            ST_SET_MIN: cmd_of = {2'b10, 8'h82, mn};
            ST_SET_SEC: cmd_of = {2'b10, 8'h80, sc & 8'h7F};  // CH=0 keeps oscillator running
            ST_RD_SEC:  cmd_of = {2'b01, 8'h81, 8'h00};
            ST_RD_MIN:  cmd_of = {2'b01, 8'h83, 8'h00};
            ST_RD_HR:   cmd_of = {2'b01, 8'h85, 8'h00};
            default:    cmd_of = 18'd0;
        endcase
    endfunction

    // Successor of a transaction state once its transfer completes.
    function automatic state_t seq_next(input state_t s);
        case (s)
            ST_SET_HR:  seq_next = ST_SET_MIN;
            ST_SET_MIN: seq_next = ST_SET_SEC;
            ST_RD_SEC:  seq_next = ST_RD_MIN;
            ST_RD_MIN:  seq_next = ST_RD_HR;
            ST_RD_HR:   seq_next = ST_REPORT;
            default:    seq_next = ST_IDLE;
        endcase
    endfunction

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        w_state_n    = r_state;
        w_phase_n    = r_phase;
        w_start_n    = r_start;
        w_addr_n     = r_addr;
        w_wdata_n    = r_wdata;
        w_sec_n      = r_sec;
        w_min_n      = r_min;
        w_hour_n     = r_hour;
        w_poll_n     = r_poll;
        w_to_n       = r_to;
        w_gap_n      = r_gap;
        w_abort_n    = r_abort;
        w_err_n      = r_err;
        w_pend_n     = r_pend;
        w_pb_sec_n   = r_pb_sec;
        w_pb_min_n   = r_pb_min;
        w_pb_hour_n  = r_pb_hour;
        w_act_sec_n  = r_act_sec;
        w_act_min_n  = r_act_min;
        w_act_hour_n = r_act_hour;
        w_set_start  = 1'b0;
        w_seq        = seq_next(r_state);
        w_cmd        = cmd_of(r_state, r_act_hour, r_act_min, r_act_sec);
        w_cmd_nxt    = cmd_of(w_seq, r_act_hour, r_act_min, r_act_sec);

        case (r_state)
            ST_IDLE: begin
                if (r_pend) begin
                    // A pending set wins over a poll; its values are frozen here
                    // so a later Set_Sig only refills the buffer.
                    w_state_n    = ST_SET_HR;
                    w_phase_n    = PH_ISSUE;
                    w_abort_n    = 1'b0;
                    w_set_start  = 1'b1;
                    w_act_sec_n  = r_pb_sec;
                    w_act_min_n  = r_pb_min;
                    w_act_hour_n = r_pb_hour;
                end else if (r_poll == POLL_CYCLES - 24'd1) begin
                    w_state_n = ST_RD_SEC;
                    w_phase_n = PH_ISSUE;
                    w_abort_n = 1'b0;
                    w_poll_n  = 24'd0;
                end else begin
                    w_poll_n = r_poll + 24'd1;
                end
            end
            ST_REPORT: begin
                w_state_n = ST_IDLE;
                w_phase_n = PH_ISSUE;
            end
            default: begin
                case (r_phase)
                    PH_ISSUE: begin
                        {w_start_n, w_addr_n, w_wdata_n} = w_cmd;
                        w_to_n    = 16'd0;
                        w_phase_n = PH_WAIT;
                    end
                    PH_WAIT: begin
                        if (bus.Done_Sig) begin
                            w_start_n = 2'b00;
                            w_phase_n = PH_GAP;
                            w_gap_n   = 1'b0;
                            if (r_state == ST_RD_SEC) w_sec_n  = bus.Read_Data & 8'h7F;
                            if (r_state == ST_RD_MIN) w_min_n  = bus.Read_Data & 8'h7F;
                            if (r_state == ST_RD_HR)  w_hour_n = bus.Read_Data;
                        end else if (r_to == TIMEOUT_CYCLES - 16'd1) begin
                            w_start_n = 2'b00;
                            w_err_n   = 1'b1;
                            w_abort_n = 1'b1;
                            w_phase_n = PH_GAP;
                            w_gap_n   = 1'b0;
                        end else begin
                            w_to_n = r_to + 16'd1;
                        end
                    end
                    default: begin
                        // Two quiet cycles; the following transfer is issued on
                        // the exit edge so exactly two idle cycles separate commands.
                        if (!r_gap) begin
                            w_gap_n = 1'b1;
                        end else if (r_abort || w_seq == ST_IDLE || w_seq == ST_REPORT) begin
                            w_state_n = r_abort ? ST_IDLE : w_seq;
                            w_phase_n = PH_ISSUE;
                        end else begin
                            w_state_n = w_seq;
                            w_phase_n = PH_WAIT;
                            w_to_n    = 16'd0;
                            {w_start_n, w_addr_n, w_wdata_n} = w_cmd_nxt;
                        end
                    end
                endcase
            end
        endcase

        // Set requests are accepted in any state; the newest one wins.
        if (Set_Sig) begin
            w_pend_n    = 1'b1;
            w_pb_sec_n  = Set_Sec;
            w_pb_min_n  = Set_Min;
            w_pb_hour_n = Set_Hour;
        end else if (w_set_start) begin
            w_pend_n = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= ST_INIT_WP;
            r_phase    <= PH_ISSUE;
            r_start    <= 2'b00;
            r_addr     <= 8'h00;
            r_wdata    <= 8'h00;
            r_sec      <= 8'h00;
            r_min      <= 8'h00;
            r_hour     <= 8'h00;
            r_poll     <= 24'd0;
            r_to       <= 16'd0;
            r_gap      <= 1'b0;
            r_abort    <= 1'b0;
            r_err      <= 1'b0;
            r_update   <= 1'b0;
            r_busy     <= 1'b0;
            r_pend     <= 1'b0;
            r_pb_sec   <= 8'h00;
            r_pb_min   <= 8'h00;
            r_pb_hour  <= 8'h00;
            r_act_sec  <= 8'h00;
            r_act_min  <= 8'h00;
            r_act_hour <= 8'h00;
        end else begin
            r_state    <= w_state_n;
            r_phase    <= w_phase_n;
            r_start    <= w_start_n;
            r_addr     <= w_addr_n;
            r_wdata    <= w_wdata_n;
            r_sec      <= w_sec_n;
            r_min      <= w_min_n;
            r_hour     <= w_hour_n;
            r_poll     <= w_poll_n;
            r_to       <= w_to_n;
            r_gap      <= w_gap_n;
            r_abort    <= w_abort_n;
            r_err      <= w_err_n;
            r_update   <= (w_state_n == ST_REPORT);
            r_busy     <= (w_state_n != ST_IDLE);
            r_pend     <= w_pend_n;
            r_pb_sec   <= w_pb_sec_n;
            r_pb_min   <= w_pb_min_n;
            r_pb_hour  <= w_pb_hour_n;
            r_act_sec  <= w_act_sec_n;
            r_act_min  <= w_act_min_n;
            r_act_hour <= w_act_hour_n;
        end
    end

    assign bus.Start_Sig  = r_start;
    assign bus.Words_Addr = r_addr;
    assign bus.Write_Data = r_wdata;
    assign Sec_Data       = r_sec;
    assign Min_Data       = r_min;
    assign Hour_Data      = r_hour;
    assign Update_Sig     = r_update;
    assign Busy           = r_busy;
    assign Err_Sig        = r_err;
    assign o_dbg_state    = r_state;
    assign o_dbg_phase    = r_phase;
endmodule

// File: tb/tb_ds1302_control_module.sv
// Bench for ds1302_control_module: responder model on the serial bus, command
// and update scoreboards, directed scenarios.
module tb_ds1302_control_module;
    localparam logic [3:0] S_INIT = 4'd0, S_IDLE = 4'd1, S_SET_SEC = 4'd4;
    localparam logic [3:0] S_RD_SEC = 4'd5, S_RD_MIN = 4'd6, S_REPORT = 4'd8;
    localparam int W = 26;  // {start[1:0], addr[7:0], data[7:0], gap[7:0]}; gap 0 = any

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       Set_Sig = 1'b0;
    logic [7:0] Set_Sec = 8'h00, Set_Min = 8'h00, Set_Hour = 8'h00;
    logic [7:0] Sec_Data, Min_Data, Hour_Data;
    logic       Update_Sig, Busy, Err_Sig;
    logic [3:0] dbg_state;
    logic [1:0] dbg_phase;

    ds1302_control_module_if bus();

    ds1302_control_module #(.POLL_CYCLES(24'd100), .TIMEOUT_CYCLES(16'd64)) dut (
        .CLK(CLK), .RESET(RESET), .Set_Sig(Set_Sig),
        .Set_Sec(Set_Sec), .Set_Min(Set_Min), .Set_Hour(Set_Hour),
        .bus(bus),
        .Sec_Data(Sec_Data), .Min_Data(Min_Data), .Hour_Data(Hour_Data),
        .Update_Sig(Update_Sig), .Busy(Busy), .Err_Sig(Err_Sig),
        .o_dbg_state(dbg_state), .o_dbg_phase(dbg_phase)
    );

    // Clock
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [23:0]  exp_upd_q[$];
    logic       resp_en = 1'b1;
    logic [7:0] rd_sec = 8'hB5, rd_min = 8'h42, rd_hr = 8'h23;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [1:0] st, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] gap);
        exp_q.push_back({st, a, d, gap});
    endtask

    task automatic push_poll(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        push_cmd(2'b01, 8'h81, 8'h00, 8'd0);
        push_cmd(2'b01, 8'h83, 8'h00, 8'd2);
        push_cmd(2'b01, 8'h85, 8'h00, 8'd2);
        exp_upd_q.push_back({h, m, s});
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int n = 0;
        while (dbg_state !== s && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check8(name, {4'd0, dbg_state}, {4'd0, s});
    endtask

    task automatic wait_busy(input logic v, input int budget, input string name);
        int n = 0;
        while (Busy !== v && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check8(name, {7'd0, Busy}, {7'd0, v});
    endtask

    task automatic set_pulse(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        Set_Hour = h;
        Set_Min  = m;
        Set_Sec  = s;
        Set_Sig  = 1'b1;
        @(negedge CLK);
        Set_Sig  = 1'b0;
    endtask

    // Responder: Done_Sig 40 cycles after a command appears, with read data by address.
    int resp_cnt = 0;
    initial begin
        bus.Done_Sig  = 1'b0;
        bus.Read_Data = 8'h00;
        forever begin
            @(negedge CLK);
            bus.Done_Sig = 1'b0;
            if (bus.Start_Sig == 2'b00) begin
                resp_cnt = 0;
            end else begin
                resp_cnt++;
                if (resp_cnt == 40 && resp_en) begin
                    bus.Done_Sig = 1'b1;
                    case (bus.Words_Addr)
                        8'h81:   bus.Read_Data = rd_sec;
                        8'h83:   bus.Read_Data = rd_min;
                        8'h85:   bus.Read_Data = rd_hr;
                        default: bus.Read_Data = 8'hEE;
                    endcase
                end
            end
        end
    end

    // Monitor: compares each new command and each Update_Sig pulse against the queues.
    logic [1:0]   prev_start = 2'b00;
    logic [17:0]  prev_cmd = 18'd0;
    logic         prev_upd = 1'b0;
    int           zero_run = 0;
    logic [W-1:0] e;
    logic [23:0]  eu;
    initial begin
        forever begin
            @(negedge CLK);
            if (bus.Start_Sig == 2'b00) begin
                if (zero_run < 255) zero_run++;
            end else begin
                if (prev_start == 2'b00) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL cmd: got unexpected %b/%h/%h expected none",
                                 bus.Start_Sig, bus.Words_Addr, bus.Write_Data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({bus.Start_Sig, bus.Words_Addr, bus.Write_Data} !== e[25:8] ||
                            (e[7:0] != 8'd0 && zero_run != int'(e[7:0]))) begin
                            errors++;
                            $display("FAIL cmd: got %b/%h/%h gap %0d expected %b/%h/%h gap %0d",
                                     bus.Start_Sig, bus.Words_Addr, bus.Write_Data, zero_run,
                                     e[25:24], e[23:16], e[15:8], e[7:0]);
                        end
                    end
                end else begin
                    checks++;
                    if ({bus.Start_Sig, bus.Words_Addr, bus.Write_Data} !== prev_cmd) begin
                        errors++;
                        $display("FAIL cmd_hold: got %h expected %h",
                                 {bus.Start_Sig, bus.Words_Addr, bus.Write_Data}, prev_cmd);
                    end
                end
                zero_run = 0;
            end
            prev_start = bus.Start_Sig;
            prev_cmd   = {bus.Start_Sig, bus.Words_Addr, bus.Write_Data};
            if (Update_Sig) begin
                checks++;
                if (prev_upd) begin
                    errors++;
                    $display("FAIL update_len: got pulse longer than 1 cycle expected 1");
                end else if (exp_upd_q.size() == 0) begin
                    errors++;
                    $display("FAIL update: got unexpected pulse %h%h%h expected none",
                             Hour_Data, Min_Data, Sec_Data);
                end else begin
                    eu = exp_upd_q.pop_front();
                    if ({Hour_Data, Min_Data, Sec_Data} !== eu) begin
                        errors++;
                        $display("FAIL update: got %h expected %h",
                                 {Hour_Data, Min_Data, Sec_Data}, eu);
                    end
                end
            end
            prev_upd = Update_Sig;
        end
    end

    // Directed scenarios
    initial begin
        int n;
        repeat (3) @(negedge CLK);
        check8("rst_start", {6'd0, bus.Start_Sig}, 8'h00);
        check8("rst_addr", bus.Words_Addr, 8'h00);
        check8("rst_wdata", bus.Write_Data, 8'h00);
        check8("rst_sec", Sec_Data, 8'h00);
        check8("rst_min", Min_Data, 8'h00);
        check8("rst_hour", Hour_Data, 8'h00);
        check8("rst_flags", {5'd0, Update_Sig, Busy, Err_Sig}, 8'h00);
        check8("rst_state", {4'd0, dbg_state}, {4'd0, S_INIT});

        // Write-protect clear, then first poll.
        push_cmd(2'b10, 8'h8E, 8'h00, 8'd0);
        push_poll(8'h23, 8'h42, 8'h35);
        RESET = 1'b0;
        wait_busy(1'b1, 20, "init_busy_hi");
        wait_busy(1'b0, 200, "init_busy_lo");
        check8("idle_state", {4'd0, dbg_state}, {4'd0, S_IDLE});
        wait_state(S_REPORT, 600, "poll1_report");
        check8("poll1_sec", Sec_Data, 8'h35);
        check8("poll1_min", Min_Data, 8'h42);
        check8("poll1_hour", Hour_Data, 8'h23);

        // Set during a poll: poll finishes first, then the writes.
        rd_sec = 8'h59; rd_min = 8'h07; rd_hr = 8'h92;
        push_poll(8'h92, 8'h07, 8'h59);
        push_cmd(2'b10, 8'h84, 8'h12, 8'd0);
        push_cmd(2'b10, 8'h82, 8'h34, 8'd2);
        push_cmd(2'b10, 8'h80, 8'h56, 8'd2);
        wait_state(S_RD_MIN, 600, "poll2_rdmin");
        set_pulse(8'h12, 8'h34, 8'hD6);
        wait_state(S_SET_SEC, 600, "set1_sec");
        wait_busy(1'b0, 200, "set1_done");
        check8("set1_q_empty", exp_q.size()[7:0], 8'd0);
        check8("set1_sec_kept", Sec_Data, 8'h59);

        // Two sets while busy: last one wins.
        push_poll(8'h92, 8'h07, 8'h59);
        push_cmd(2'b10, 8'h84, 8'h45, 8'd0);
        push_cmd(2'b10, 8'h82, 8'h56, 8'd2);
        push_cmd(2'b10, 8'h80, 8'h07, 8'd2);
        wait_state(S_RD_SEC, 600, "poll3_rdsec");
        set_pulse(8'h11, 8'h22, 8'h33);
        repeat (4) @(negedge CLK);
        set_pulse(8'h45, 8'h56, 8'h07);
        wait_state(S_SET_SEC, 800, "set2_sec");
        wait_busy(1'b0, 200, "set2_done");
        check8("set2_q_empty", exp_q.size()[7:0], 8'd0);

        // Timeout: no Done_Sig, sequence abandoned, data unchanged.
        resp_en = 1'b0;
        push_cmd(2'b01, 8'h81, 8'h00, 8'd0);
        wait_state(S_RD_SEC, 600, "to_rdsec");
        n = 0;
        while (bus.Start_Sig == 2'b00 && n < 20) begin @(negedge CLK); n++; end
        n = 0;
        while (bus.Start_Sig != 2'b00 && n < 200) begin @(negedge CLK); n++; end
        check8("to_len", n[7:0], 8'd64);
        check8("to_err", {7'd0, Err_Sig}, 8'h01);
        wait_busy(1'b0, 20, "to_idle");
        check8("to_state", {4'd0, dbg_state}, {4'd0, S_IDLE});
        check8("to_sec", Sec_Data, 8'h59);
        check8("to_min", Min_Data, 8'h07);
        check8("to_hour", Hour_Data, 8'h92);

        // Next poll still runs; Err_Sig stays set.
        resp_en = 1'b1;
        rd_sec = 8'h92; rd_min = 8'hC5; rd_hr = 8'h11;
        push_poll(8'h11, 8'h45, 8'h12);
        wait_state(S_REPORT, 600, "poll4_report");
        check8("err_sticky", {7'd0, Err_Sig}, 8'h01);
        wait_busy(1'b0, 20, "poll4_done");

        // Reset in the middle of a read.
        push_cmd(2'b01, 8'h81, 8'h00, 8'd0);
        push_cmd(2'b01, 8'h83, 8'h00, 8'd2);
        wait_state(S_RD_MIN, 600, "poll5_rdmin");
        repeat (10) @(negedge CLK);
        check8("mid_q_empty", exp_q.size()[7:0], 8'd0);
        exp_q.delete();
        RESET = 1'b1;
        @(negedge CLK);
        check8("mrst_start", {6'd0, bus.Start_Sig}, 8'h00);
        check8("mrst_addr", bus.Words_Addr, 8'h00);
        check8("mrst_wdata", bus.Write_Data, 8'h00);
        check8("mrst_data", Sec_Data | Min_Data | Hour_Data, 8'h00);
        check8("mrst_flags", {5'd0, Update_Sig, Busy, Err_Sig}, 8'h00);
        check8("mrst_state", {4'd0, dbg_state}, {4'd0, S_INIT});
        push_cmd(2'b10, 8'h8E, 8'h00, 8'd0);
        @(negedge CLK);
        RESET = 1'b0;
        wait_busy(1'b1, 20, "reinit_busy_hi");
        wait_busy(1'b0, 200, "reinit_busy_lo");

        repeat (5) @(negedge CLK);
        check8("final_cmd_q", exp_q.size()[7:0], 8'd0);
        check8("final_upd_q", exp_upd_q.size()[7:0], 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
